// File: rtl/timer_pkg.sv
// Shared types and field widths for the timer count controller.
// Optional HALT support is built in with macro TIMER_HALT_EN.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int DIV_MAX   = 8;
   localparam int DIV_VAL_W = 4;
   localparam int EXP_W     = 4;

   // Prescale exponent actually applied; oversized div_val clamps to DIV_MAX.
   function automatic logic [EXP_W-1:0] eff_exp(
      input logic                 div_en,
      input logic [DIV_VAL_W-1:0] div_val
   );
      if (!div_en)
         return '0;
      if (div_val > DIV_VAL_W'(DIV_MAX))
         return EXP_W'(DIV_MAX);
      return div_val;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler counter: clear, hold and terminal-count strobe.
// Period restarts whenever the effective exponent changes.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr,
   input  logic [EXP_W-1:0] k,
   output logic             tick
);

   logic [PSC_W-1:0] psc_cnt;
   logic [EXP_W-1:0] k_q;
   logic [PSC_W:0]   span;
   logic [PSC_W-1:0] term;
   logic             chg;
   logic             tc;

   assign span = (PSC_W+1)'(1) << k;
   assign term = PSC_W'(span - (PSC_W+1)'(1));
   assign chg  = (k != k_q);
   assign tc   = (psc_cnt == term);
   assign tick = run & tc & ~chg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psc_cnt <= '0;
         k_q     <= '0;
      end else begin
         k_q <= k;
         if (clr)
            psc_cnt <= '0;
         else if (run)
            psc_cnt <= (chg | tc) ? '0 : psc_cnt + PSC_W'(1);
      end
   end

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer count controller: IDLE/RUN/HALT FSM driving the counter strobe.
// HALT state and halt_ack exist only when TIMER_HALT_EN is defined.
module timer_cnt_ctrl
   import timer_pkg::*;
#(
   parameter int PSC_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 timer_en,
   input  logic                 div_en,
   input  logic [DIV_VAL_W-1:0] div_val,
   input  logic                 halt_req,
   input  logic                 dbg_mode,
   output logic                 cnt_en,
   output logic                 halt_ack,
   output logic                 running
);

   state_t           state;
   state_t           state_nx;
   logic             run;
   logic             clr;
   logic             tick;
   logic [EXP_W-1:0] k;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (timer_en) state_nx = RUN;
`ifdef TIMER_HALT_EN
         RUN: begin
            if (!timer_en)
               state_nx = IDLE;
            else if (halt_req & dbg_mode)
               state_nx = HALT;
         end
         HALT: begin
            if (!timer_en)
               state_nx = IDLE;
            else if (!(halt_req & dbg_mode))
               state_nx = RUN;
         end
`else
         RUN:  if (!timer_en) state_nx = IDLE;
         HALT: state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      run     = (state == RUN);
      running = (state != IDLE);
      clr     = (state_nx == IDLE);
      // A strobe never leaves during a reset cycle.
      cnt_en  = rst_n & tick;
   end

   assign k = eff_exp(div_en, div_val);

   timer_prescaler #(
      .PSC_W (PSC_W)
   ) u_psc (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .clr   (clr),
      .k     (k),
      .tick  (tick)
   );

`ifdef TIMER_HALT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         halt_ack <= 1'b0;
      else
         halt_ack <= (state_nx == HALT);
   end
`else
   logic unused_halt;
   assign unused_halt = halt_req ^ dbg_mode;
   assign halt_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Directed bench for timer_cnt_ctrl; expectations follow the
// TIMER_HALT_EN setting of the build.
module tb_timer_cnt_ctrl;

`ifdef TIMER_HALT_EN
   localparam bit H = 1'b1;
`else
   localparam bit H = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       timer_en;
   logic       div_en;
   logic [3:0] div_val;
   logic       halt_req;
   logic       dbg_mode;
   logic       cnt_en;
   logic       halt_ack;
   logic       running;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   timer_cnt_ctrl #(.PSC_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .timer_en (timer_en),
      .div_en   (div_en),
      .div_val  (div_val),
      .halt_req (halt_req),
      .dbg_mode (dbg_mode),
      .cnt_en   (cnt_en),
      .halt_ack (halt_ack),
      .running  (running)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else begin
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
         $error("check %s", tag);
      end
   endtask

   task automatic wait_strobe(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (cnt_en) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, first, second, cnt;
      rst_n = 1'b0; timer_en = 1'b0; div_en = 1'b0;
      div_val = 4'd0; halt_req = 1'b0; dbg_mode = 1'b0;
      tick(); tick();
      chk("rst_cnt_en", int'(cnt_en), 0);
      chk("rst_halt_ack", int'(halt_ack), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_psc", int'(dut.u_psc.psc_cnt), 0);
      rst_n = 1'b1;
      tick();

      // undivided: strobe on every RUN cycle
      timer_en = 1'b1;
      #1;
      chk("div0_idle_cycle", int'(cnt_en), 0);
      cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (cnt_en) cnt++;
      end
      chk("div0_strobes", cnt, 10);
      chk("div0_running", int'(running), 1);
      timer_en = 1'b0;
      tick();
      chk("div0_off_running", int'(running), 0);
      chk("div0_off_cnt_en", int'(cnt_en), 0);

      // divide by 4
      div_en = 1'b1; div_val = 4'd2; timer_en = 1'b1;
      cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("div4_c%0d", i), int'(cnt_en), int'(i % 4 == 0));
         if (cnt_en) cnt++;
      end
      chk("div4_strobes", cnt, 3);
      timer_en = 1'b0;
      tick();

      // clamped exponent: period 256
      div_val = 4'hF; timer_en = 1'b1;
      first = 0; second = 0; cnt = 0;
      for (int i = 1; i <= 520; i++) begin
         tick();
         if (cnt_en) begin
            cnt++;
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
      end
      chk("clamp_first", first, 256);
      chk("clamp_second", second, 512);
      chk("clamp_count", cnt, 2);
      timer_en = 1'b0;
      tick();

      // exponent change in RUN restarts the period
      div_val = 4'd2; timer_en = 1'b1;
      tick(); tick();
      chk("chg_psc_before", int'(dut.u_psc.psc_cnt), 1);
      div_val = 4'd1;
      #1;
      chk("chg_suppress", int'(cnt_en), 0);
      tick();
      chk("chg_psc_clr", int'(dut.u_psc.psc_cnt), 0);
      chk("chg_c1", int'(cnt_en), 0);
      tick();
      chk("chg_c2", int'(cnt_en), 1);
      timer_en = 1'b0;
      tick();

      // halt mid-period at psc_cnt=1
      div_val = 4'd2; timer_en = 1'b1;
      tick(); tick();
      halt_req = 1'b1; dbg_mode = 1'b1;
      tick();
      chk("halt_ack_rise", int'(halt_ack), int'(H));
      chk("halt_a_cnt", int'(cnt_en), 0);
      chk("halt_running", int'(running), 1);
      tick();
      chk("halt_b_cnt", int'(cnt_en), H ? 0 : 1);
      tick();
      chk("halt_c_cnt", int'(cnt_en), 0);
      halt_req = 1'b0;
      tick();
      chk("halt_ack_fall", int'(halt_ack), 0);
      chk("halt_d_cnt", int'(cnt_en), 0);
      chk("halt_d_psc", int'(dut.u_psc.psc_cnt), H ? 2 : 1);
      tick();
      chk("halt_e_cnt", int'(cnt_en), H ? 1 : 0);
      timer_en = 1'b0; dbg_mode = 1'b0;
      tick();

      // disable wins over a simultaneous halt request
      timer_en = 1'b1;
      tick(); tick(); tick();
      timer_en = 1'b0; halt_req = 1'b1; dbg_mode = 1'b1;
      tick();
      chk("race_running", int'(running), 0);
      chk("race_halt_ack", int'(halt_ack), 0);
      chk("race_psc", int'(dut.u_psc.psc_cnt), 0);
      chk("race_cnt_en", int'(cnt_en), 0);
      tick();
      chk("idle_halt_running", int'(running), 0);
      timer_en = 1'b1;
      tick();
      chk("enter_run_running", int'(running), 1);
      chk("enter_run_ack", int'(halt_ack), 0);
      tick();
      chk("late_halt_ack", int'(halt_ack), int'(H));
      timer_en = 1'b0; halt_req = 1'b0; dbg_mode = 1'b0;
      tick();

      // reset during RUN aborts the period
      div_val = 4'd3; timer_en = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("pre_rst_strobe", int'(cnt_en), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_cycle_cnt_en", int'(cnt_en), 0);
      tick();
      chk("midrst_cnt_en", int'(cnt_en), 0);
      chk("midrst_halt_ack", int'(halt_ack), 0);
      chk("midrst_running", int'(running), 0);
      chk("midrst_psc", int'(dut.u_psc.psc_cnt), 0);
      rst_n = 1'b1;
      wait_strobe(20, n);
      chk("post_rst_first", n, 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/timer_cnt_ctrl.md
TIMER_CNT_CTRL -- requirements
Module: timer_cnt_ctrl

Interface
REQ-001 SHALL have parameter PSC_W, default 8, prescaler counter width; must be at least DIV_MAX.
REQ-002 SHALL have clock and reset: clk input, 1 bit, single clock; rst_n input, 1 bit, reset synchronous and active-low.
REQ-003 SHALL have timer_en input, 1 bit: count enable from the TCR register.
REQ-004 SHALL have div_en input, 1 bit: prescaler enable.
REQ-005 SHALL have div_val input, 4 bits: prescale exponent; period is 2^div_val clocks.
REQ-006 SHALL have halt_req input, 1 bit: halt request from the THCSR register.
REQ-007 SHALL have dbg_mode input, 1 bit: debug mode qualifier; halt is honoured only while it is 1.
REQ-008 SHALL have cnt_en output, 1 bit: one-clock increment strobe to the 64-bit counter.
REQ-009 SHALL have halt_ack output, 1 bit: halt acknowledge, read back through THCSR bit 1.
REQ-010 SHALL have running output, 1 bit: 1 while in RUN or HALT.

Function
REQ-011 SHALL implement a 3-state FSM with states IDLE, RUN and HALT.
REQ-012 SHALL transition IDLE->RUN on the clock edge where timer_en=1.
REQ-013 SHALL transition RUN->IDLE or HALT->IDLE on the edge where timer_en=0; this takes priority over every other transition.
REQ-014 SHALL transition RUN->HALT on the edge where halt_req=1 and dbg_mode=1.
REQ-015 SHALL transition HALT->RUN on the edge where halt_req=0 or dbg_mode=0.
REQ-016 SHALL compute the effective exponent as 0 when div_en=0, otherwise min(div_val, DIV_MAX); values 9-15 clamp to 8.
REQ-017 SHALL, in RUN with effective exponent 0, drive cnt_en=1 on every cycle.
REQ-018 SHALL, in RUN with effective exponent k>0, increment psc_cnt each cycle; cnt_en=1 (combinational) in the cycle psc_cnt==2^k-1, and psc_cnt wraps to 0 on that edge.
REQ-019 SHALL produce the first cnt_en on the 2^k-th RUN cycle after entering RUN from IDLE.
REQ-020 SHALL, in HALT, drive cnt_en=0 and freeze psc_cnt; on resuming RUN, psc_cnt continues from the held value with no phase loss.
REQ-021 SHALL, in IDLE, drive cnt_en=0 and hold psc_cnt at 0; psc_cnt is cleared on the edge entering IDLE.
REQ-022 SHALL clear psc_cnt on the edge after any change of effective exponent in RUN, restarting the period; cnt_en is suppressed in that cycle.
REQ-023 SHALL drive halt_ack registered, =1 exactly while the state is HALT; it rises one clock after the halt_req/dbg_mode edge and falls in the cycle the state leaves HALT.
REQ-024 SHALL resolve simultaneous timer_en 1->0 and halt_req=1 as a transition to IDLE, with halt_ack staying 0.
REQ-025 SHALL cause no state change from halt_req=1 while in IDLE; if halt_req is still asserted on entering RUN, HALT follows one clock later.

Reset
REQ-026 SHALL, when rst_n=0 at a clk edge, set state=IDLE, psc_cnt=0, halt_ack=0, cnt_en=0, running=0.
REQ-027 SHALL abort any period in progress on reset mid-operation; no cnt_en is issued in the reset cycle.
REQ-028 SHALL have no asynchronous reset path.

Configuration
REQ-029 SHALL, with macro TIMER_HALT_EN defined, implement the HALT state and the halt_ack logic as specified above.
REQ-030 SHALL, without TIMER_HALT_EN, compile out the HALT state: halt_req and dbg_mode are ignored, halt_ack is tied 0, and the FSM is IDLE/RUN only.

Structure
REQ-031 SHALL place the state enum (IDLE, RUN, HALT), DIV_MAX=8 and the register-field width constants in shared package timer_pkg.
REQ-032 SHALL place the prescaler counter, with its clear, hold and terminal-count logic, in one sub-module, timer_prescaler; the FSM and halt handshake stay in timer_cnt_ctrl.

Verification
REQ-033 SHALL cover: timer_en=1, div_en=0 -> cnt_en high every cycle from the 2nd cycle after timer_en; 10 strobes in 10 RUN cycles.
REQ-034 SHALL cover: div_en=1, div_val=2 -> cnt_en pulses on RUN cycles 4, 8, 12; exactly 1 of every 4 cycles.
REQ-035 SHALL cover: div_val=4'hF, div_en=1 -> period of 256 cycles (clamped to 8).
REQ-036 SHALL cover: dbg_mode=1, halt_req pulse mid-period at psc_cnt=1 with div_val=2 -> halt_ack=1 the next cycle, no cnt_en while halted, and the next strobe exactly 2 RUN cycles after release.
REQ-037 SHALL cover: timer_en 1->0 on the same edge as halt_req=1 -> IDLE, halt_ack stays 0, and psc_cnt reads 0.
REQ-038 SHALL cover: rst_n=0 for one clock during RUN with div_val=3 -> all outputs 0 the next cycle; after release and timer_en=1, the first strobe comes after 8 RUN cycles.
